// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Consumes the UART receiver byte stream and assembles SYNC, LEN, PAYLOAD[LEN], CHK
// frames. Payload bytes are streamed out as they arrive. The frame is then
// validated by length, by XOR checksum and by an inter-byte timeout.
// Every output is registered, so each pulse appears one clock after its accept cycle.
module uart_frame_parser #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int          TIMEOUT_CLKS = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_finish,
  output logic [7:0] payload_byte,
  output logic       payload_valid,
  output logic       frame_done,
  output logic       frame_error,
  output logic [1:0] err_code,
  output logic [7:0] frame_len
);

  // The timeout counter only has to reach TIMEOUT_CLKS-1.
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CLKS > 0) ? TW'(TIMEOUT_CLKS - 1) : '0;
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t        state_reg;
  logic          rx_prev_reg;
  logic [7:0]    chk_reg;
  logic [7:0]    cnt_reg;
  logic [7:0]    len_reg;
  logic [TW-1:0] to_cnt_reg;

  logic accept;
  logic timeout_hit;
  logic last_payload;

  // A byte is accepted only on the rising edge of rx_finish. The timeout fires only
  // mid-frame and only when it is enabled.
  always_comb begin
    accept       = rx_finish & ~rx_prev_reg;
    timeout_hit  = (TIMEOUT_CLKS != 0) && (state_reg != S_SYNC) && (to_cnt_reg == TO_LAST);
    last_payload = ({1'b0, cnt_reg} + 9'd1) == {1'b0, len_reg};
  end

  // Frame FSM with registered outputs. An accepted byte takes priority over a timeout
  // expiry in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_SYNC;
      rx_prev_reg   <= 1'b0;
      chk_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      to_cnt_reg    <= '0;
      payload_byte  <= '0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      err_code      <= '0;
      frame_len     <= '0;
    end else begin
      rx_prev_reg   <= rx_finish;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;

      // The timeout counter idles while hunting and restarts on every accepted byte.
      if (state_reg == S_SYNC || accept) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (accept) begin
        case (state_reg)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              chk_reg   <= '0;
              state_reg <= S_LEN;
            end
          end
          S_LEN: begin
            chk_reg <= rx_data;
            cnt_reg <= '0;
            len_reg <= rx_data;
            if ({1'b0, rx_data} > MAX_LEN9) begin
              frame_error <= 1'b1;
              err_code    <= ERR_LEN;
              state_reg   <= S_SYNC;
            end else if (rx_data == 8'd0) begin
              state_reg <= S_CHECK;
            end else begin
              state_reg <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            payload_byte  <= rx_data;
            payload_valid <= 1'b1;
            chk_reg       <= chk_reg ^ rx_data;
            cnt_reg       <= cnt_reg + 8'd1;
            if (last_payload) begin
              state_reg <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (rx_data == chk_reg) begin
              frame_done <= 1'b1;
              frame_len  <= len_reg;
            end else begin
              frame_error <= 1'b1;
              err_code    <= ERR_CHK;
            end
            state_reg <= S_SYNC;
          end
          default: state_reg <= S_SYNC;
        endcase
      end else if (timeout_hit) begin
        frame_error <= 1'b1;
        err_code    <= ERR_TIMEOUT;
        state_reg   <= S_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: directed frames from the test plan plus a
// randomized frame stream. Each frame's expected events come from its construction:
// payload bytes, then done with LEN or an error code.
module tb_uart_frame_parser;

  localparam int CLK_PERIOD = 10;
  localparam int MAX_LEN    = 16;
  localparam int TO_CLKS    = 50;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_finish;
  logic [7:0] payload_byte;
  logic       payload_valid;
  logic       frame_done;
  logic       frame_error;
  logic [1:0] err_code;
  logic [7:0] frame_len;

  int checks   = 0;
  int failures = 0;

  // Event records: {kind, value}. Kind 1 is payload, 2 is done (value is LEN),
  // and 3 is error (value is the code).
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  time last_acc_time;
  time err_time;

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_finish    (rx_finish),
    .payload_byte (payload_byte),
    .payload_valid(payload_valid),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .err_code     (err_code),
    .frame_len    (frame_len)
  );

  always #(CLK_PERIOD / 2) clock = ~clock;

  // Observe the output pulses on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (payload_valid) obs_q.push_back({8'h01, payload_byte});
      if (frame_done)    obs_q.push_back({8'h02, frame_len});
      if (frame_error) begin
        obs_q.push_back({8'h03, 6'd0, err_code});
        err_time = $time;
      end
      if (frame_done || frame_error) begin
        checks++;
        if (frame_done && frame_error) begin
          failures++;
          $display("FAIL done_error_exclusive: both asserted at %0t, required one", $time);
        end
      end
    end
  end

  initial begin
    #(CLK_PERIOD * 60000);
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Present one byte: rx_finish is high for 'hold' cycles, then low for 'gap' cycles.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data   = b;
    rx_finish = 1'b1;
    @(posedge clock);
    last_acc_time = $time;
    repeat (hold - 1) @(posedge clock);
    #1;
    rx_finish = 1'b0;
    rx_data   = 8'($urandom);
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_list(input logic [7:0] seq [$]);
    foreach (seq[i]) send_byte(seq[i], 1, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Build one frame and record what it should produce. kind 0 is good, kind 1 has a
  // bad checksum, and kind 2 has an oversize length.
  task automatic send_frame(input int len, input int kind);
    logic [7:0] chk;
    logic [7:0] b;
    send_byte(SYNC, $urandom_range(1, 3), $urandom_range(1, 4));
    send_byte(8'(len), $urandom_range(1, 3), $urandom_range(1, 4));
    if (kind == 2) begin
      exp_q.push_back({8'h03, 8'h01});
      return;
    end
    chk = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      chk ^= b;
      exp_q.push_back({8'h01, b});
      send_byte(b, $urandom_range(1, 3), $urandom_range(1, 4));
    end
    if (kind == 1) begin
      chk ^= 8'($urandom_range(1, 255));
      exp_q.push_back({8'h03, 8'h02});
    end else begin
      exp_q.push_back({8'h02, 8'(len)});
    end
    send_byte(chk, $urandom_range(1, 3), $urandom_range(1, 4));
  endtask

  task automatic test_reset;
    idle(2);
    checks++; if (payload_byte  !== 8'h00) begin failures++; $display("FAIL reset_payload_byte: got %h want 00", payload_byte); end
    checks++; if (payload_valid !== 1'b0)  begin failures++; $display("FAIL reset_payload_valid: got %b want 0", payload_valid); end
    checks++; if (frame_done    !== 1'b0)  begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (frame_error   !== 1'b0)  begin failures++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    checks++; if (err_code      !== 2'b00) begin failures++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    checks++; if (frame_len     !== 8'h00) begin failures++; $display("FAIL reset_frame_len: got %h want 00", frame_len); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    send_list('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    exp_q = '{16'h0111, 16'h0122, 16'h0133, 16'h0203};
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL good_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL good_frame_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (frame_len !== 8'd3) begin failures++; $display("FAIL good_frame_len_held: got %0d want 3", frame_len); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_checksum;
    send_list('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    idle(3);
    checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL bad_chk_err_code: got %b want 10", err_code); end
    send_list('{8'hAA, 8'h01, 8'h5A, 8'h5B});
    exp_q = '{16'h0111, 16'h0122, 16'h0133, 16'h0302, 16'h015A, 16'h0201};
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL bad_chk_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bad_chk_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL bad_chk_err_code_held: got %b want 10", err_code); end
    checks++; if (frame_len !== 8'd1) begin failures++; $display("FAIL bad_chk_next_len: got %0d want 1", frame_len); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_length_edges;
    send_list('{8'hAA, 8'h00, 8'h00});
    exp_q.push_back(16'h0200);
    send_frame(MAX_LEN, 0);
    send_list('{8'hAA, 8'h11, 8'h01, 8'h02, 8'h03, 8'hAA, 8'h01, 8'h07, 8'h06});
    exp_q.push_back(16'h0301);
    exp_q.push_back(16'h0107);
    exp_q.push_back(16'h0201);
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL len_edges_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL len_edges_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL len_edges_err_code: got %b want 01", err_code); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_sync_hunt;
    send_list('{8'h55, 8'h00, 8'hFF, 8'hAA});
    send_byte(8'h01, 3, 1);
    send_byte(8'hAA, 3, 2);
    send_byte(8'hAB, 1, 1);
    exp_q = '{16'h01AA, 16'h0201};
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL sync_hunt_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL sync_hunt_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout;
    time t_acc;
    err_time = 0;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h11, 1, 0);
    t_acc = last_acc_time;
    idle(TO_CLKS + 10);
    checks++; if (err_time - t_acc !== time'(TO_CLKS * CLK_PERIOD + CLK_PERIOD / 2)) begin
      failures++; $display("FAIL timeout_latency: got %0t want %0t", err_time - t_acc, time'(TO_CLKS * CLK_PERIOD + CLK_PERIOD / 2));
    end
    checks++; if (err_code !== 2'b11) begin failures++; $display("FAIL timeout_err_code: got %b want 11", err_code); end
    exp_q = '{16'h0111, 16'h0303};
    // The parser is back in sync hunting: a fresh frame must parse.
    send_list('{8'hAA, 8'h01, 8'h44, 8'h45});
    exp_q.push_back(16'h0144);
    exp_q.push_back(16'h0201);
    // A byte accepted on the expiry cycle keeps the frame alive.
    send_byte(8'hAA, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h11, 1, 0);
    idle(TO_CLKS - 1);
    send_byte(8'h22, 1, 1);
    send_byte(8'h31, 1, 1);
    exp_q.push_back(16'h0111);
    exp_q.push_back(16'h0122);
    exp_q.push_back(16'h0202);
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL timeout_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    send_list('{8'hAA, 8'h04, 8'h01, 8'h02});
    exp_q = '{16'h0101, 16'h0102};
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      checks++; if ({payload_byte, payload_valid, frame_done, frame_error, err_code, frame_len} !== 21'd0) begin
        failures++; $display("FAIL reset_mid_outputs: got pb=%h pv=%b fd=%b fe=%b ec=%b fl=%h want all 0",
                             payload_byte, payload_valid, frame_done, frame_error, err_code, frame_len);
      end
    end
    reset = 1'b0;
    idle(2);
    send_list('{8'hAA, 8'h01, 8'h07, 8'h06});
    exp_q.push_back(16'h0107);
    exp_q.push_back(16'h0201);
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL reset_mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL reset_mid_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (frame_len !== 8'd1) begin failures++; $display("FAIL reset_mid_len: got %0d want 1", frame_len); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_frames;
    int kind;
    logic [7:0] junk;
    for (int f = 0; f < 40; f++) begin
      // Noise between frames, never equal to SYNC, must be ignored.
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 254));
        if (junk == SYNC) junk = 8'h55;
        send_byte(junk, $urandom_range(1, 3), $urandom_range(1, 4));
      end
      kind = $urandom_range(0, 5);
      if (kind <= 3)      send_frame($urandom_range(0, MAX_LEN), 0);
      else if (kind == 4) send_frame($urandom_range(0, MAX_LEN), 1);
      else                send_frame($urandom_range(MAX_LEN + 1, 255), 2);
    end
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    rx_finish = 1'b0;
    rx_data   = 8'h00;
    @(posedge clock);
    #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_edges();
    test_sync_hunt();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its rx_data/rx_finish byte stream.
- Assembles bytes into framed packets of the form SYNC, LEN, PAYLOAD[LEN], CHK, and streams payload bytes to the command layer.
- Validates each frame's length and checksum and enforces an inter-byte timeout.
- Reports frame completion or an error code to the consumer.

Parameters:
- MAX_LEN, 16, largest accepted payload length in bytes (1..255).
- SYNC_BYTE, 8'hAA, frame start marker.
- TIMEOUT_CLKS, 100000, inter-byte timeout in clock cycles while mid-frame; 0 disables the timeout.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from the UART receiver; valid when rx_finish is high.
- rx_finish  input  1  byte-received flag from the UART receiver.
- payload_byte  output  8  current payload byte.
- payload_valid  output  1  one-cycle pulse per payload byte.
- frame_done  output  1  one-cycle pulse when a frame passes the checksum check.
- frame_error  output  1  one-cycle pulse when a frame is aborted.
- err_code  output  2  error cause, held until the next frame_error or reset.
  - 01 = length exceeds MAX_LEN.
  - 10 = checksum mismatch.
  - 11 = timeout.
- frame_len  output  8  LEN of the last frame that completed with frame_done; held.

Behaviour:
- One clock, "clock"; reset is synchronous and active-high, "reset". All outputs are registered.
- Reset values:
  - All outputs are 0; state is S_SYNC.
  - Checksum, byte counter, timeout counter and the rx_finish edge register are cleared.
- Byte accept rule:
  - A byte is accepted on the rising edge of rx_finish, i.e. rx_finish=1 while the previous-cycle sample was 0.
  - rx_finish held high for several cycles yields exactly one byte.
  - rx_data is sampled in the accept cycle.
- Latency: each pulse output asserts the cycle after the accept cycle (1 clock) and lasts one cycle.
- State S_SYNC:
  - Accepted byte == SYNC_BYTE -> S_LEN, and chk is cleared.
  - Any other byte is silently discarded.
  - The timeout counter is idle in this state.
- State S_LEN:
  - Accepted byte L: chk <= L and the byte counter is cleared.
  - L > MAX_LEN -> frame_error with err_code=01, then S_SYNC.
  - L == 0 -> S_CHECK.
  - Otherwise -> S_PAYLOAD, and L is latched internally.
- State S_PAYLOAD:
  - Each accepted byte B drives payload_byte=B with a payload_valid pulse, and chk <= chk ^ B. The counter increments.
  - When the counter reaches L -> S_CHECK.
- State S_CHECK:
  - Accepted byte C == chk -> frame_done pulse and frame_len <= L.
  - Otherwise -> frame_error with err_code=10.
  - Either way, the next state is S_SYNC.
- Checksum: 8-bit XOR of LEN and all payload bytes. SYNC_BYTE and CHK are excluded.
- Timeout:
  - In S_LEN, S_PAYLOAD and S_CHECK, the counter increments every cycle and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CLKS-1 -> frame_error with err_code=11, then S_SYNC.
  - If a byte accept and the timeout expiry fall in the same cycle, the byte wins: the counter clears and there is no error.
- Payload is streamed before validation. The consumer must discard buffered payload on frame_error.
- frame_done and frame_error never assert in the same cycle.
- A SYNC_BYTE value inside LEN, PAYLOAD or CHK is treated as data, not as a resync.
- Reset mid-frame aborts without a frame_error pulse, and returns all state to reset values.

Test Plan:
- Good frame AA 03 11 22 33 03 -> payload_valid x3 with 11, 22, 33; one frame_done; frame_len=3; frame_error never asserted.
- Bad checksum: AA 03 11 22 33 04 -> three payload pulses, then frame_error with err_code=10 and no frame_done. A following AA 01 5A 5B is accepted: frame_done, frame_len=1.
- Length edge cases with MAX_LEN=16:
  - AA 00 00 -> frame_done, frame_len=0, no payload pulses.
  - AA 10 with 16 bytes and the correct CHK -> accepted.
  - AA 11 -> frame_error with err_code=01 right after the LEN byte; the next bytes are ignored until AA.
- Sync hunting and edge detect:
  - 55 00 FF AA 01 AA AB -> only the frame after the first AA is parsed. Payload AA is treated as data; frame_done with CHK AB.
  - rx_finish held high 3 cycles on one byte -> counted once.
- Timeout with TIMEOUT_CLKS=50:
  - AA 02 11, then idle -> frame_error with err_code=11 exactly 50 cycles after the last accept; the state returns to sync.
  - A byte arriving on the expiry cycle -> no error.
- Reset mid-payload (after AA 04 01 02), then AA 01 07 06 -> no error pulse from the reset, all outputs 0 during reset, then a clean frame_done with frame_len=1.
